// File: rtl/mem_op_sequencer.sv
// Multi-cycle sequencer for ALU reg-imm, load and store commands driving a register-file/RAM datapath.
// Optional OVERFLOW_TRAP_EN: an ALU overflow in EXEC aborts the command with err and no writes.
module mem_op_sequencer #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [2:0]  cmd_alu_op,
  input  logic [4:0]  cmd_rs,
  input  logic [4:0]  cmd_rt,
  input  logic [15:0] cmd_offset,
  output logic [4:0]  dp_rs,
  output logic [4:0]  dp_rt,
  output logic [4:0]  dp_waddr,
  output logic [15:0] dp_offset,
  output logic [2:0]  dp_alu_op,
  output logic        dp_write_reg,
  output logic        dp_mem_write,
  output logic        dp_wsel,
  input  logic        dp_of,
  input  logic        dp_zf,
  output logic        done,
  output logic        err,
  output logic        flag_of,
  output logic        flag_zf
);

  typedef enum logic [2:0] {StIdle, StExec, StMem, StWb, StDone} state_e;

  localparam logic [1:0] OpAlu   = 2'b00;
  localparam logic [1:0] OpLoad  = 2'b01;
  localparam logic [1:0] OpStore = 2'b10;
  localparam logic [1:0] OpRsv   = 2'b11;
  localparam logic [2:0] AluAdd  = 3'd4;
  localparam logic [1:0] LatInit = 2'(MEM_LAT - 1);

  state_e      state_q, state_d;
  logic [1:0]  op_q;
  logic [2:0]  alu_op_q;
  logic [4:0]  rs_q, rt_q;
  logic [15:0] offset_q;
  logic [1:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        flag_of_q, flag_zf_q;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q   <= StIdle;
      op_q      <= '0;
      alu_op_q  <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      offset_q  <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      flag_of_q <= 1'b0;
      flag_zf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (state_q == StIdle && cmd_valid) begin
        op_q     <= cmd_op;
        alu_op_q <= cmd_alu_op;
        rs_q     <= cmd_rs;
        rt_q     <= cmd_rt;
        offset_q <= cmd_offset;
      end
      if (state_q == StExec) begin
        flag_of_q <= dp_of;
        flag_zf_q <= dp_zf;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          err_d   = (cmd_op == OpRsv);
          state_d = (cmd_op == OpRsv) ? StDone : StExec;
        end
      end
      StExec: begin
        cnt_d = LatInit;
`ifdef OVERFLOW_TRAP_EN
        if (dp_of) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          state_d = (op_q == OpAlu) ? StWb : StMem;
        end
`else
        state_d = (op_q == OpAlu) ? StWb : StMem;
`endif
      end
      StMem: begin
        // Stores spend one cycle here; loads wait out the RAM latency.
        if (op_q == OpStore) begin
          state_d = StDone;
        end else if (cnt_q == 2'd0) begin
          state_d = StWb;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      StWb:    state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign cmd_ready    = (state_q == StIdle);
  assign done         = (state_q == StDone);
  assign err          = (state_q == StDone) && err_q;
  assign dp_rs        = rs_q;
  assign dp_rt        = rt_q;
  assign dp_waddr     = rt_q;
  assign dp_offset    = offset_q;
  assign dp_alu_op    = (op_q == OpAlu) ? alu_op_q : AluAdd;
  assign dp_mem_write = (state_q == StMem) && (op_q == OpStore);
  // r0 is hardwired, so its write strobe is dropped without changing timing.
  assign dp_write_reg = (state_q == StWb) && (rt_q != 5'd0);
  assign dp_wsel      = (state_q == StWb) && (op_q != OpLoad);
  assign flag_of      = flag_of_q;
  assign flag_zf      = flag_zf_q;

endmodule
